// File: rtl/ps2_frame_receiver_pkg.sv
// Shared types and constants for the PS/2 receive path and its scancode consumers.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_SHIFT  = 8'h12;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// PS/2 pins plus the byte handshake toward the scancode handler.
interface ps2_frame_receiver_if;
  import ps2_pkg::*;

  logic                     ps2_clk;
  logic                     ps2_data;
  logic                     nextdata_n;
  logic [PS2_DATA_BITS-1:0] data;
  logic                     ready;
  logic                     overflow;
  logic                     parity_err;
  logic                     frame_err;

  // master: the side driving the pins and consuming bytes
  modport master (
    output ps2_clk, ps2_data, nextdata_n,
    input  data, ready, overflow, parity_err, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, nextdata_n,
    output data, ready, overflow, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_frame_receiver_sync_edge.sv
// Pin synchronisers; data is delayed by the same two flops as the clock so the
// bit presented with fall is the one that was on the line at the falling edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic bit_val
);
  logic [2:0] clk_sr;
  logic [1:0] dat_sr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sr <= 3'b111;
      dat_sr <= 2'b11;
    end else begin
      clk_sr <= {clk_sr[1:0], ps2_clk};
      dat_sr <= {dat_sr[0], ps2_data};
    end
  end

  // clk_sr[2] is the older sample
  assign fall    = clk_sr[2] & ~clk_sr[1];
  assign bit_val = dat_sr[1];
endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver with show-ahead byte FIFO.
//   state  | meaning
//   IDLE   | waiting for a start bit (0) on a ps2_clk fall
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop/parity, pushing the byte or flagging an error
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input logic                 clk,
  input logic                 clr,
  ps2_frame_receiver_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DATA   = DATA;
  localparam logic [1:0] ST_PARITY = PARITY;
  localparam logic [1:0] ST_STOP   = STOP;

  logic                     fall;
  logic                     bit_val;
  logic [1:0]               state;
  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     par_bit;
  logic [TW-1:0]            tcnt;
  logic                     perr_q;
  logic                     ferr_q;
  logic                     push_req;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .clr      (clr),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .fall     (fall),
    .bit_val  (bit_val)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!bit_val) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {bit_val, shreg[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= bit_val;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!bit_val)                 ferr_q <= 1'b1;
            else if (!(^shreg ^ par_bit)) perr_q <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state == ST_IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // counter would reach TIMEOUT_CYCLES this cycle: abandon the frame
        state  <= ST_IDLE;
        ferr_q <= 1'b1;
        tcnt   <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  assign push_req = fall && (state == ST_STOP) && bit_val && (^shreg ^ par_bit);

  logic [PS2_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW-1:0]            rd_next;
  logic [AW:0]              count;
  logic [PS2_DATA_BITS-1:0] data_q;
  logic                     ovf_q;
  logic                     pop;
  logic                     full;
  logic                     do_push;

  assign pop     = !bus.nextdata_n && (count != '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push_req && (!full || pop);
  assign rd_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_next;
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // registered head so data keeps the last entry once the FIFO drains
      if (pop) begin
        if (count > (AW+1)'(1)) data_q <= mem[rd_next];
        else if (do_push)       data_q <= shreg;
      end else if (do_push && (count == '0)) begin
        data_q <= shreg;
      end
      if (pop)                   ovf_q <= 1'b0;
      else if (push_req && full) ovf_q <= 1'b1;
    end
  end

  assign bus.data       = data_q;
  assign bus.ready      = (count != '0);
  assign bus.overflow   = ovf_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
endmodule
